// File: rtl/mat_alu_pkg.sv
// rtl/mat_alu_pkg.sv - shared constants and enums for the 3x3 matrix ALU sequencer
// Contents: ALU select codes, element count, command opcode enum, sequencer FSM state enum.
package mat_alu_pkg;

    localparam int ELEMS = 9;

    // ALU select map: 0..8 write E, 9..17 write F, 18..26 read G,
    // 27 determinant (used here as a parking code that writes nothing), 28..31 ops.
    localparam logic [5:0] SEL_E_BASE = 6'd0;
    localparam logic [5:0] SEL_F_BASE = 6'd9;
    localparam logic [5:0] SEL_G_BASE = 6'd18;
    localparam logic [5:0] SEL_DET    = 6'd27;
    localparam logic [5:0] SEL_TRANS  = 6'd28;
    localparam logic [5:0] SEL_ADD    = 6'd29;
    localparam logic [5:0] SEL_SUB    = 6'd30;
    localparam logic [5:0] SEL_MUL    = 6'd31;

    typedef enum logic [1:0] {
        OP_TRANS = 2'd0,
        OP_ADD   = 2'd1,
        OP_SUB   = 2'd2,
        OP_MUL   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_E   = 3'd1,
        ST_LOAD_F   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_SETTLE_W = 3'd4,
        ST_DRAIN    = 3'd5
    } state_e;

endpackage

// File: rtl/mat_idx_counter.sv
// rtl/mat_idx_counter.sv - mod-9 element index counter
// Ports: clk, reset (async, active-high), clear (sync to 0), inc (advance, wraps 8->0),
//        idx (current index 0..8), last (idx == 8).
module mat_idx_counter
    import mat_alu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] idx,
    output logic       last
);

    assign last = (idx == 4'(ELEMS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= 4'd0;
        end else if (clear) begin
            idx <= 4'd0;
        end else if (inc) begin
            idx <= last ? 4'd0 : idx + 4'd1;
        end
    end

endmodule

// File: rtl/mat_alu_sequencer.sv
// rtl/mat_alu_sequencer.sv - command/operand/result sequencer for the 3x3 matrix ALU
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_err command channel;
//        in_valid/in_ready/in_data operand stream (E then F, row-major);
//        out_valid/out_ready/out_data/out_last result stream (G row-major);
//        busy; alu_sel/alu_ele_in (registered) and alu_ele_out to/from the ALU.
// Build option: MAT_SEQ_MUL_EN enables op 3 (E*F); without it op 3 is rejected via cmd_err.
module mat_alu_sequencer
    import mat_alu_pkg::*;
#(
    parameter int DW     = 32,
    parameter int SETTLE = 1
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    output logic          cmd_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic [5:0]    alu_sel,
    output logic [DW-1:0] alu_ele_in,
    input  logic [DW-1:0] alu_ele_out
);

    localparam logic [1:0] SETTLE_C = 2'(SETTLE);

    state_e        state, next_state;
    op_e           op, op_next;
    logic [5:0]    sel_next;
    logic [DW-1:0] ele_next;
    logic          err_next;
    logic [1:0]    settle_cnt, settle_next;
    logic          op_ok;

    logic          ld_clear, ld_inc, ld_last;
    logic [3:0]    ld_idx;
    logic          rd_clear, rd_inc, rd_last;
    logic [3:0]    rd_idx;

`ifdef MAT_SEQ_MUL_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (op_e'(cmd_op) != OP_MUL);
`endif

    mat_idx_counter u_ld_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (ld_clear),
        .inc   (ld_inc),
        .idx   (ld_idx),
        .last  (ld_last)
    );

    mat_idx_counter u_rd_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (rd_clear),
        .inc   (rd_inc),
        .idx   (rd_idx),
        .last  (rd_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // alu_sel/alu_ele_in are registered, so every decision made in a state
    // becomes visible on the ALU bus one cycle later. The last operand write
    // therefore lands in the EXEC cycle and the op select in the first
    // SETTLE_W cycle, followed by SETTLE parked cycles before readback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op         <= OP_TRANS;
            alu_sel    <= SEL_DET;
            alu_ele_in <= '0;
            cmd_err    <= 1'b0;
            settle_cnt <= 2'd0;
        end else begin
            op         <= op_next;
            alu_sel    <= sel_next;
            alu_ele_in <= ele_next;
            cmd_err    <= err_next;
            settle_cnt <= settle_next;
        end
    end

    always_comb begin
        next_state  = state;
        op_next     = op;
        sel_next    = SEL_DET;
        ele_next    = alu_ele_in;
        err_next    = 1'b0;
        settle_next = settle_cnt;
        ld_clear    = 1'b0;
        ld_inc      = 1'b0;
        rd_clear    = 1'b0;
        rd_inc      = 1'b0;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_next  = op_e'(cmd_op);
                    ld_clear = 1'b1;
                    rd_clear = 1'b1;
                    if (op_ok) begin
                        next_state = ST_LOAD_E;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD_E: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_next = SEL_E_BASE + {2'b00, ld_idx};
                    ele_next = in_data;
                    ld_inc   = 1'b1;
                    if (ld_last) begin
                        next_state = (op == OP_TRANS) ? ST_EXEC : ST_LOAD_F;
                    end
                end
            end
            ST_LOAD_F: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sel_next = SEL_F_BASE + {2'b00, ld_idx};
                    ele_next = in_data;
                    ld_inc   = 1'b1;
                    if (ld_last) begin
                        next_state = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                sel_next    = SEL_TRANS + {4'b0000, op};
                settle_next = 2'd0;
                next_state  = ST_SETTLE_W;
            end
            ST_SETTLE_W: begin
                if (settle_cnt == SETTLE_C) begin
                    sel_next   = SEL_G_BASE;
                    next_state = ST_DRAIN;
                end else begin
                    settle_next = settle_cnt + 2'd1;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                sel_next  = alu_sel;
                if (out_ready) begin
                    rd_inc = 1'b1;
                    if (rd_last) begin
                        sel_next   = SEL_DET;
                        next_state = ST_IDLE;
                    end else begin
                        // Advance the read select on the same edge as rd_idx so
                        // out_data always corresponds to the current beat.
                        sel_next = SEL_G_BASE + {2'b00, rd_idx} + 6'd1;
                    end
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign out_data = alu_ele_out;
    assign out_last = out_valid & rd_last;
    assign busy     = (state != ST_IDLE);

endmodule
